controller_poller: RTL and testbench

// - Polls the two NES-style serial gamepads and presents each as a parallel button byte for the
//   CPU-bus read decode (controller 1 and controller 2 read ports).
// - Drives the shared controller_clk and controller_latch pins.
// - Deserialises the two active-low data lines.
// - Updates both bytes atomically once per poll, so the CPU never reads a half-shifted value.
// - A poll starts on a one-cycle start pulse, normally the start of vblank.

---
 rtl/controller_pkg.sv | 31 +++
 rtl/pad_shift_in.sv | 32 +++
 rtl/controller_poller.sv | 138 +++++++++++++
 tb/tb_controller_poller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// ============================================================================
// controller_pkg : shared types and constants for the gamepad poller
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } poll_state_t;

  localparam int BUTTONS_W = 8;

  // Bit positions inside a button byte (first serial bit lands in bit 7)
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

`default_nettype wire

// File: rtl/pad_shift_in.sv
// ============================================================================
// pad_shift_in : 8-bit MSB-first deserialiser for one active-low pad line
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_shift_in
  import controller_pkg::*;
(
  input  logic                 clk_1,
  input  logic                 rst_B,
  input  logic                 sample,
  input  logic                 commit,
  input  logic                 data_in_B,
  output logic [BUTTONS_W-1:0] data_out
);

  logic [BUTTONS_W-1:0] shift_r;

  always_ff @(posedge clk_1) begin
    if (!rst_B) begin
      shift_r  <= '0;
      data_out <= '0;
    end else begin
      if (sample) shift_r <= {shift_r[BUTTONS_W-2:0], ~data_in_B};
      if (commit) data_out <= shift_r;
    end
  end

endmodule

`default_nettype wire

// File: rtl/controller_poller.sv
// ============================================================================
// controller_poller : polls two NES pads and presents atomic button bytes
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_poller
  import controller_pkg::*;
#(
  parameter int LATCH_CYCLES = 12,
  parameter int HALF_CYCLES  = 3
) (
  input  logic                 clk_1,
  input  logic                 rst_B,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 controller_clk,
  output logic                 controller_latch,
  input  logic                 controller_1_data_in_B,
  input  logic                 controller_2_data_in_B,
  output logic [BUTTONS_W-1:0] controller_1_data_out,
  output logic [BUTTONS_W-1:0] controller_2_data_out
);

  localparam int MAX_P = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  generate
    if (LATCH_CYCLES < 1 || HALF_CYCLES < 1) begin : g_param_check
      $error("controller_poller: LATCH_CYCLES and HALF_CYCLES must be >= 1");
    end
  endgenerate

  poll_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic             latch_end;
  logic             half_end;
  logic             sample;
  logic             commit;

  assign latch_end = (cnt == CNT_W'(LATCH_CYCLES - 1));
  assign half_end  = (cnt == CNT_W'(HALF_CYCLES - 1));
  // Sample on the last low cycle, i.e. the edge that also raises controller_clk
  assign sample    = (state == LOW) && half_end;
  assign commit    = (state == HIGH) && half_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk_1) begin
    if (!rst_B) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_cnt          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      controller_clk   <= 1'b0;
      controller_latch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state            <= LATCH;
            busy             <= 1'b1;
            controller_latch <= 1'b1;
            cnt              <= '0;
            bit_cnt          <= '0;
          end
        end
        LATCH: begin
          if (latch_end) begin
            state            <= LOW;
            controller_latch <= 1'b0;
            cnt              <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (half_end) begin
            state          <= HIGH;
            controller_clk <= 1'b1;
            cnt            <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            controller_clk <= 1'b0;
            cnt            <= '0;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= LOW;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          busy             <= 1'b0;
          done             <= 1'b0;
          controller_clk   <= 1'b0;
          controller_latch <= 1'b0;
        end
      endcase
    end
  end

  pad_shift_in u_pad1 (
    .clk_1     (clk_1),
    .rst_B     (rst_B),
    .sample    (sample),
    .commit    (commit),
    .data_in_B (controller_1_data_in_B),
    .data_out  (controller_1_data_out)
  );

  pad_shift_in u_pad2 (
    .clk_1     (clk_1),
    .rst_B     (rst_B),
    .sample    (sample),
    .commit    (commit),
    .data_in_B (controller_2_data_in_B),
    .data_out  (controller_2_data_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_controller_poller.sv
// ============================================================================
// tb_controller_poller : directed and randomized checks against a pad model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_poller;

  logic       clk_1 = 1'b0;
  logic       rst_B = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, controller_clk, controller_latch;
  logic       d1, d2;
  logic [7:0] out1, out2;

  controller_poller dut (
    .clk_1                  (clk_1),
    .rst_B                  (rst_B),
    .start                  (start),
    .busy                   (busy),
    .done                   (done),
    .controller_clk         (controller_clk),
    .controller_latch       (controller_latch),
    .controller_1_data_in_B (d1),
    .controller_2_data_in_B (d2),
    .controller_1_data_out  (out1),
    .controller_2_data_out  (out2)
  );

  always #5 clk_1 = ~clk_1;

  // Pad model: latch loads the buttons, each controller_clk rise advances one bit
  logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
  logic       tie1_en = 1'b0, tie2_en = 1'b0;
  logic       tie1_val = 1'b1, tie2_val = 1'b1;
  int         idx = 8;

  always @(posedge controller_latch) idx = 0;
  always @(posedge controller_clk) if (idx < 8) idx = idx + 1;

  always @* begin
    d1 = tie1_en ? tie1_val : ((idx < 8) ? ~pad1[3'(7 - idx)] : 1'b0);
    d2 = tie2_en ? tie2_val : ((idx < 8) ? ~pad2[3'(7 - idx)] : 1'b0);
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp1 = 8'h00, exp2 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One poll, observed cycle by cycle. Cycle n is the n-th clock period after
  // the edge that accepts start. chg: cycle at which pad1 switches to p1n.
  task automatic poll(input logic [7:0] p1, input logic [7:0] p2, input int chg,
                      input logic [7:0] p1n, input int x1, input int x2, input int rst_at);
    logic [7:0] e1, e2;
    int         latch_cnt, rise_cnt, both_cnt, done_cnt;
    logic       prev_clk;
    pad1 = p1;
    pad2 = p2;
    // Bit i is sampled at the end of cycle LATCH + 2*HALF*i + HALF = 15 + 6i
    for (int i = 0; i < 8; i++) begin
      e1[7-i] = (chg > 0 && chg <= 15 + 6 * i) ? p1n[7-i] : p1[7-i];
    end
    e2 = p2;
    if (tie1_en) e1 = {8{~tie1_val}};
    if (tie2_en) e2 = {8{~tie2_val}};
    latch_cnt = 0; rise_cnt = 0; both_cnt = 0; done_cnt = 0; prev_clk = 1'b0;
    @(negedge clk_1);
    start = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk_1);
      if (n == chg) pad1 = p1n;
      if (rst_at > 0 && n == rst_at + 1) begin
        exp1 = 8'h00;
        exp2 = 8'h00;
        chk("rst_busy", busy, 0);
        chk("rst_latch", controller_latch, 0);
        chk("rst_clk", controller_clk, 0);
        chk("rst_done", done, 0);
        chk("rst_out1", out1, exp1);
        chk("rst_out2", out2, exp2);
        rst_B = 1'b1;
        return;
      end
      if (n == 61) begin
        exp1 = e1;
        exp2 = e2;
      end
      chk("latch", controller_latch, (n <= 12) ? 1 : 0);
      chk("cclk", controller_clk, (n >= 13 && n <= 60 && ((n - 13) % 6) >= 3) ? 1 : 0);
      chk("busy", busy, (n <= 61) ? 1 : 0);
      chk("done", done, (n == 61) ? 1 : 0);
      chk("out1", out1, exp1);
      chk("out2", out2, exp2);
      if (controller_latch) latch_cnt++;
      if (controller_clk && !prev_clk) rise_cnt++;
      if (controller_clk && controller_latch) both_cnt++;
      if (done) done_cnt++;
      prev_clk = controller_clk;
      start = (n == x1 || n == x2);
      if (rst_at > 0 && n == rst_at) rst_B = 1'b0;
    end
    start = 1'b0;
    chk("latch_cycles", latch_cnt, 12);
    chk("clk_rises", rise_cnt, 8);
    chk("both_high", both_cnt, 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk_1);
    @(negedge clk_1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_latch", controller_latch, 0);
    chk("reset_clk", controller_clk, 0);
    chk("reset_out1", out1, 8'h00);
    chk("reset_out2", out2, 8'h00);
    rst_B = 1'b1;
    repeat (2) @(negedge clk_1);

    // Normal poll plus pin timing
    poll(8'h89, 8'h26, 0, 8'h00, 0, 0, 0);

    // Starts during the poll and in the DONE cycle are dropped, then a fresh poll
    poll(8'($urandom), 8'($urandom), 0, 8'h00, 20, 61, 0);
    poll(8'h89, 8'h26, 0, 8'h00, 0, 0, 0);

    // Reset mid-shift, then a fresh poll
    poll(8'h5A, 8'hC3, 0, 8'h00, 0, 0, 30);
    repeat (2) @(negedge clk_1);
    poll(8'h89, 8'h26, 0, 8'h00, 0, 0, 0);

    // Pad 1 changes to 0xFF mid-poll
    poll(8'h12, 8'h34, 30, 8'hFF, 0, 0, 0);

    // Pad 2 unplugged (line high), pad 1 line stuck low
    tie1_en = 1'b1; tie1_val = 1'b0;
    tie2_en = 1'b1; tie2_val = 1'b1;
    poll(8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    tie1_en = 1'b0; tie2_en = 1'b0;

    // Randomized polls, some with a mid-poll pad-1 change
    for (int r = 0; r < 6; r++) begin
      poll(8'($urandom), 8'($urandom),
           (r % 2 == 1) ? int'($urandom_range(13, 60)) : 0,
           8'($urandom), 0, 0, 0);
    end

    // start coincident with reset is not accepted
    @(negedge clk_1);
    start = 1'b1;
    rst_B = 1'b0;
    @(negedge clk_1);
    start = 1'b0;
    rst_B = 1'b1;
    exp1 = 8'h00;
    exp2 = 8'h00;
    for (int n = 0; n < 4; n++) begin
      chk("rst_start_busy", busy, 0);
      chk("rst_start_latch", controller_latch, 0);
      @(negedge clk_1);
    end
    chk("rst_start_out1", out1, exp1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
